// File: rtl/uart_word_link.sv
// Word-to-byte bridge between the UART memory controller and an 8-bit AXI-stream UART core.
// TX splits a 32-bit word into four bytes LSB first; RX reassembles four bytes and drops stale partial words.
module uart_word_link #(
    parameter int unsigned TimeoutCycles = 120000,
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] tx_word_i,
    input  logic        tx_word_valid_i,
    output logic        tx_word_ready_o,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic [31:0] rx_word_o,
    output logic        rx_word_valid_o,
    input  logic        rx_word_ready_i,
    output logic        rx_timeout_o
);

    typedef enum logic {TxIdle, TxSend} tx_state_e;
    typedef enum logic {RxCollect, RxHold} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [31:0]      tx_shift_q, tx_shift_d;
    logic [1:0]       tx_idx_q, tx_idx_d;

    rx_state_e        rx_state_q, rx_state_d;
    logic [31:0]      rx_word_q, rx_word_d;
    logic [1:0]       rx_idx_q, rx_idx_d;
    logic [CntW-1:0]  rx_cnt_q, rx_cnt_d;
    logic             rx_timeout_q, rx_timeout_d;
    logic             rx_byte_hs;

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_state_q   <= TxIdle;
            tx_shift_q   <= '0;
            tx_idx_q     <= '0;
            rx_state_q   <= RxCollect;
            rx_word_q    <= '0;
            rx_idx_q     <= '0;
            rx_cnt_q     <= '0;
            rx_timeout_q <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_shift_q   <= tx_shift_d;
            tx_idx_q     <= tx_idx_d;
            rx_state_q   <= rx_state_d;
            rx_word_q    <= rx_word_d;
            rx_idx_q     <= rx_idx_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_timeout_q <= rx_timeout_d;
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_word_valid_i) begin
                    tx_shift_d = tx_word_i;
                    tx_idx_d   = 2'd0;
                    tx_state_d = TxSend;
                end
            end
            TxSend: begin
                if (m_axis_tready_i) begin
                    tx_shift_d = {8'h00, tx_shift_q[31:8]};
                    tx_idx_d   = tx_idx_q + 2'd1;
                    if (tx_idx_q == 2'd3) begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // Handshake outputs come straight from state, so tready never reaches tx_word_ready_o combinationally.
    assign tx_word_ready_o = (tx_state_q == TxIdle);
    assign m_axis_tvalid_o = (tx_state_q == TxSend);
    assign m_axis_tdata_o  = tx_shift_q[7:0];

    assign rx_byte_hs = (rx_state_q == RxCollect) && s_axis_tvalid_i;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_word_d    = rx_word_q;
        rx_idx_d     = rx_idx_q;
        rx_cnt_d     = rx_cnt_q;
        rx_timeout_d = 1'b0;
        unique case (rx_state_q)
            RxCollect: begin
                if (rx_byte_hs) begin
                    rx_word_d[{rx_idx_q, 3'b000} +: 8] = s_axis_tdata_i;
                    rx_idx_d = rx_idx_q + 2'd1;
                    rx_cnt_d = '0;
                    if (rx_idx_q == 2'd3) begin
                        rx_state_d = RxHold;
                    end
                end else if (rx_idx_q != 2'd0) begin
                    // A byte landing on the final allowed cycle takes the branch above and wins.
                    if (rx_cnt_q == CntW'(TimeoutCycles - 1)) begin
                        rx_timeout_d = 1'b1;
                        rx_idx_d     = 2'd0;
                        rx_cnt_d     = '0;
                        rx_word_d    = '0;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CntW'(1);
                    end
                end
            end
            RxHold: begin
                if (rx_word_ready_i) begin
                    rx_state_d = RxCollect;
                end
            end
            default: rx_state_d = RxCollect;
        endcase
    end

    assign s_axis_tready_o = (rx_state_q == RxCollect);
    assign rx_word_valid_o = (rx_state_q == RxHold);
    assign rx_word_o       = rx_word_q;
    assign rx_timeout_o    = rx_timeout_q;

endmodule

// File: tb/tb_uart_word_link.sv
// Scoreboard bench for uart_word_link: stimulus pushes expected bytes/words, negedge monitors pop and compare.
module tb_uart_word_link;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [31:0] tx_word_i = '0;
    logic        tx_word_valid_i = 1'b0;
    logic        tx_word_ready_o;
    logic [7:0]  m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i = 1'b1;
    logic [7:0]  s_axis_tdata_i = '0;
    logic        s_axis_tvalid_i = 1'b0;
    logic        s_axis_tready_o;
    logic [31:0] rx_word_o;
    logic        rx_word_valid_o;
    logic        rx_word_ready_i = 1'b0;
    logic        rx_timeout_o;

    int n_cmp = 0;
    int n_fail = 0;
    int n_timeouts = 0;
    int exp_timeouts = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rx_q[$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    uart_word_link #(.TimeoutCycles(TO)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .tx_word_i       (tx_word_i),
        .tx_word_valid_i (tx_word_valid_i),
        .tx_word_ready_o (tx_word_ready_o),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .rx_word_o       (rx_word_o),
        .rx_word_valid_o (rx_word_valid_o),
        .rx_word_ready_i (rx_word_ready_i),
        .rx_timeout_o    (rx_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: byte/word handshakes pop the scoreboard; stalled bytes must not change.
    always @(negedge clk) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("tx_stall_valid", 32'(m_axis_tvalid_o), 32'd1);
                check("tx_stall_data", 32'(m_axis_tdata_o), 32'(prev_data));
            end
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                if (tx_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL tx_extra_byte: got 0x%0h, required no byte", m_axis_tdata_o);
                end else begin
                    check("tx_byte", 32'(m_axis_tdata_o), 32'(tx_q.pop_front()));
                end
            end
            prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
            prev_data  = m_axis_tdata_o;
            if (rx_word_valid_o && rx_word_ready_i) begin
                if (rx_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rx_extra_word: got 0x%0h, required no word", rx_word_o);
                end else begin
                    check("rx_word", rx_word_o, rx_q.pop_front());
                end
            end
            if (rx_timeout_o) n_timeouts++;
        end
    end

    // Offer one word; waits (bounded) for acceptance and returns one cycle after the accepting edge.
    task automatic send_word(input logic [31:0] w, input int nexp);
        logic ok;
        for (int i = 0; i < nexp; i++) tx_q.push_back(w[8*i +: 8]);
        tx_word_i = w;
        tx_word_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = tx_word_ready_o;
            @(posedge clk);
            #1;
        end
        tx_word_valid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tx_word_accept: got no ready within 50 cycles, required ready");
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic ok;
        s_axis_tdata_i = b;
        s_axis_tvalid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = s_axis_tready_o;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid_i = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_byte_accept: got no tready within 50 cycles, required tready");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (tx_q.size() != 0 || rx_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_tx_q", 32'(tx_q.size()), 32'd0);
        check("drain_rx_q", 32'(rx_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", 32'(tx_word_ready_o), 32'd1);
        check("rst_s_tready", 32'(s_axis_tready_o), 32'd1);
        check("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        check("rst_rx_valid", 32'(rx_word_valid_o), 32'd0);
        check("rst_timeout", 32'(rx_timeout_o), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata_o), 32'd0);
        check("rst_rx_word", rx_word_o, 32'd0);
        @(posedge clk);
        #1;

        // TX single word: bytes in N+1..N+4, ready back in N+5.
        send_word(32'h1234_5678, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tx_seq_valid", 32'(m_axis_tvalid_o), 32'd1);
            check("tx_seq_busy", 32'(tx_word_ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("tx_ready_n5", 32'(tx_word_ready_o), 32'd1);
        check("tx_idle_valid", 32'(m_axis_tvalid_o), 32'd0);
        @(posedge clk);
        #1;

        // TX back-pressure with random tready.
        m_axis_tready_i = 1'b0;
        send_word(32'hDEAD_BEEF, 4);
        for (int i = 0; i < 200 && tx_q.size() != 0; i++) begin
            m_axis_tready_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        m_axis_tready_i = 1'b1;
        wait_drain();

        // RX assembly and hold.
        rx_word_ready_i = 1'b0;
        rx_q.push_back(32'h0403_0201);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rx_hold_valid", 32'(rx_word_valid_o), 32'd1);
            check("rx_hold_tready", 32'(s_axis_tready_o), 32'd0);
            check("rx_hold_word", rx_word_o, 32'h0403_0201);
            @(posedge clk);
            #1;
        end
        rx_word_ready_i = 1'b1;
        @(posedge clk);
        #1 rx_word_ready_i = 1'b0;
        @(negedge clk);
        check("rx_valid_drop", 32'(rx_word_valid_o), 32'd0);
        check("rx_tready_back", 32'(s_axis_tready_o), 32'd1);
        @(posedge clk);
        #1;

        // RX timeout then realigned word.
        rx_word_ready_i = 1'b1;
        exp_timeouts = 1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TO + 4) @(posedge clk);
        #1;
        check("timeout_once", 32'(n_timeouts), 32'(exp_timeouts));
        rx_q.push_back(32'h4433_2211);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_drain();

        // Boundary: second byte on the last allowed cycle is kept.
        rx_q.push_back(32'h3CC3_A55A);
        send_byte(8'h5A);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'hA5);
        send_byte(8'hC3);
        send_byte(8'h3C);
        wait_drain();
        check("timeout_boundary", 32'(n_timeouts), 32'(exp_timeouts));

        // One cycle later: the partial byte is dropped and the late byte starts a new word.
        exp_timeouts = 2;
        rx_q.push_back(32'h0504_0302);
        send_byte(8'h01);
        repeat (TO) @(posedge clk);
        #1;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_byte(8'h05);
        wait_drain();
        check("timeout_late", 32'(n_timeouts), 32'(exp_timeouts));

        // Concurrent TX and RX.
        fork
            send_word(32'hCAFE_F00D, 4);
            begin
                rx_q.push_back(32'h89AB_CDEF);
                send_byte(8'hEF);
                send_byte(8'hCD);
                send_byte(8'hAB);
                send_byte(8'h89);
            end
        join
        wait_drain();

        // Reset after two TX bytes, with a partial RX word pending.
        send_byte(8'h77);
        send_word(32'h1122_3344, 2);
        @(posedge clk);
        @(posedge clk);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rst_mid_tx_ready", 32'(tx_word_ready_o), 32'd1);
        check("rst_mid_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        check("rst_mid_rx_word", rx_word_o, 32'd0);
        check("rst_mid_s_tready", 32'(s_axis_tready_o), 32'd1);
        for (int k = 0; k < 2 * TO; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_mid_no_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        end
        check("rst_mid_no_timeout", 32'(n_timeouts), 32'(exp_timeouts));
        check("rst_mid_tx_q", 32'(tx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
